fetch_stage: RTL and testbench

//  Instruction-fetch stage plus IF/ID pipeline register; directly upstream of control_unit.
//  - Owns the PC and drives the instruction-memory address.
//  - Latches fetched instruction and its PC into IF/ID; if_id_instr[6:0] feeds control_unit.opcode.
//  - Applies stall from hazard detection and flush/redirect from ID (IF_flush, branch/jump target).

---
 rtl/fetch_stage_if.sv | 16 +
 rtl/fetch_stage.sv | 115 +++++++++++
 tb/tb_fetch_stage.sv | 193 +++++++++++++++++++
 3 files changed

// File: rtl/fetch_stage_if.sv
// fetch_stage_if
//   Instruction-memory bus between the fetch stage and its instruction store.
//   DATA_W      address / instruction width
//   imem_addr   word-aligned fetch address (driven by the fetch stage)
//   imem_rdata  instruction at imem_addr, returned in the same cycle
//   modport master : fetch-stage side
//   modport slave  : memory side
interface fetch_stage_if #(
  parameter int unsigned DATA_W = 32
);
  logic [DATA_W-1:0] imem_addr;
  logic [DATA_W-1:0] imem_rdata;

  modport master (output imem_addr, input  imem_rdata);
  modport slave  (input  imem_addr, output imem_rdata);
endinterface

// File: rtl/fetch_stage.sv
// fetch_stage
//   Instruction-fetch stage plus IF/ID pipeline register. Owns the PC, drives the
//   instruction-memory address, and latches the fetched word and its PC into IF/ID.
//   Stall holds PC and IF/ID; IF_flush inserts a bubble; redirect loads a new PC.
//
//   Optional build macro: FETCH_PERF_CNT_EN
//     defined   -> saturating fetch/flush/stall performance counters are built
//     undefined -> counter outputs are tied to zero
//
// Ports
//   clk          rising-edge clock
//   arst_n       asynchronous reset, active low
//   en           global enable; 0 freezes every register
//   stall        hold PC and IF/ID
//   IF_flush     replace IF/ID with NOP_INSTR bubble
//   redirect     load PC from redirect_pc (word-aligned)
//   redirect_pc  branch/jump target
//   imem         instruction-memory bus (master side)
//   pc           current fetch PC
//   if_id_instr  registered instruction to decode
//   if_id_pc     registered PC of if_id_instr
//   if_id_valid  1 = real instruction, 0 = bubble
//   fetch_cnt    instructions latched into IF/ID as valid
//   flush_cnt    cycles with IF_flush applied
//   stall_cnt    cycles with stall applied (flush takes precedence)
module fetch_stage #(
  parameter int unsigned        DATA_W    = 32,
  parameter logic [DATA_W-1:0]  RESET_PC  = '0,
  parameter logic [DATA_W-1:0]  NOP_INSTR = DATA_W'(32'h0000_0013),
  parameter int unsigned        CNT_W     = 32
) (
  input  logic               clk,
  input  logic               arst_n,
  input  logic               en,
  input  logic               stall,
  input  logic               IF_flush,
  input  logic               redirect,
  input  logic [DATA_W-1:0]  redirect_pc,
  fetch_stage_if.master      imem,
  output logic [DATA_W-1:0]  pc,
  output logic [DATA_W-1:0]  if_id_instr,
  output logic [DATA_W-1:0]  if_id_pc,
  output logic               if_id_valid,
  output logic [CNT_W-1:0]   fetch_cnt,
  output logic [CNT_W-1:0]   flush_cnt,
  output logic [CNT_W-1:0]   stall_cnt
);

  localparam logic [DATA_W-1:0] WORD_MASK = ~DATA_W'(3);

  // Masking keeps the memory address word-aligned even for a misaligned RESET_PC.
  assign imem.imem_addr = pc & WORD_MASK;

  // PC register
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      pc <= RESET_PC;
    end else if (en) begin
      if (redirect) begin
        pc <= redirect_pc & WORD_MASK;
      end else if (!stall) begin
        pc <= pc + DATA_W'(4);
      end
    end
  end

  // IF/ID pipeline register
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      if_id_instr <= NOP_INSTR;
      if_id_pc    <= RESET_PC;
      if_id_valid <= 1'b0;
    end else if (en) begin
      if (IF_flush) begin
        if_id_instr <= NOP_INSTR;
        if_id_pc    <= pc;
        if_id_valid <= 1'b0;
      end else if (!stall) begin
        if_id_instr <= imem.imem_rdata;
        if_id_pc    <= pc;
        if_id_valid <= 1'b1;
      end
    end
  end

`ifdef FETCH_PERF_CNT_EN
  logic fetch_evt;
  logic flush_evt;
  logic stall_evt;

  // A flushed cycle counts as a flush only, even when stall is also high.
  always_comb begin
    fetch_evt = en & ~IF_flush & ~stall;
    flush_evt = en & IF_flush;
    stall_evt = en & stall & ~IF_flush;
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      fetch_cnt <= '0;
      flush_cnt <= '0;
      stall_cnt <= '0;
    end else begin
      if (fetch_evt && (fetch_cnt != '1)) fetch_cnt <= fetch_cnt + CNT_W'(1);
      if (flush_evt && (flush_cnt != '1)) flush_cnt <= flush_cnt + CNT_W'(1);
      if (stall_evt && (stall_cnt != '1)) stall_cnt <= stall_cnt + CNT_W'(1);
    end
  end
`else
  assign fetch_cnt = '0;
  assign flush_cnt = '0;
  assign stall_cnt = '0;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
module tb_fetch_stage;

  localparam int unsigned DW = 32;
  localparam int unsigned CW = 4;   // narrow counters so saturation is reachable
  localparam logic [31:0] NOP = 32'h0000_0013;
`ifdef FETCH_PERF_CNT_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          arst_n;
  logic          en, stall, IF_flush, redirect;
  logic [DW-1:0] redirect_pc;
  logic [DW-1:0] pc, if_id_instr, if_id_pc;
  logic          if_id_valid;
  logic [CW-1:0] fetch_cnt, flush_cnt, stall_cnt;

  fetch_stage_if #(.DATA_W(DW)) imem ();

  fetch_stage #(
    .DATA_W(DW), .RESET_PC(32'h0), .NOP_INSTR(NOP), .CNT_W(CW)
  ) dut (
    .clk(clk), .arst_n(arst_n), .en(en), .stall(stall), .IF_flush(IF_flush),
    .redirect(redirect), .redirect_pc(redirect_pc), .imem(imem.slave),
    .pc(pc), .if_id_instr(if_id_instr), .if_id_pc(if_id_pc),
    .if_id_valid(if_id_valid), .fetch_cnt(fetch_cnt), .flush_cnt(flush_cnt),
    .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  // Instruction store: fixed word at 0, address-derived words elsewhere.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == 32'h0) return 32'h0050_0093;
    return {a[15:0] ^ 16'hA5C3, a[31:16] ^ a[15:0]};
  endfunction

  assign imem.imem_rdata = mem_word(imem.imem_addr);

  // Reference model
  logic [31:0] m_pc, m_instr, m_ipc;
  logic        m_valid;
  int unsigned m_fc, m_flc, m_stc;
  localparam int unsigned CMAX = (1 << CW) - 1;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int unsigned sat_inc(input int unsigned v);
    return (v >= CMAX) ? CMAX : v + 1;
  endfunction

  task automatic model_reset();
    m_pc = 0; m_instr = NOP; m_ipc = 0; m_valid = 0;
    m_fc = 0; m_flc = 0; m_stc = 0;
  endtask

  task automatic model_edge(input logic e, s, f, r, input logic [31:0] rp);
    logic [31:0] cur;
    if (!e) return;
    cur = m_pc;
    if (r)       m_pc = {rp[31:2], 2'b00};
    else if (!s) m_pc = cur + 32'd4;
    if (f) begin
      m_instr = NOP; m_ipc = cur; m_valid = 0; m_flc = sat_inc(m_flc);
    end else if (!s) begin
      m_instr = mem_word(cur); m_ipc = cur; m_valid = 1; m_fc = sat_inc(m_fc);
    end else begin
      m_stc = sat_inc(m_stc);
    end
  endtask

  task automatic step(input logic e, s, f, r, input logic [31:0] rp);
    en = e; stall = s; IF_flush = f; redirect = r; redirect_pc = rp;
    @(posedge clk);
    model_edge(e, s, f, r, rp);
    #1;
  endtask

  task automatic cmp_model(input string tag);
    chk({tag, ".pc"},    pc, m_pc);
    chk({tag, ".addr"},  imem.imem_addr, m_pc);
    chk({tag, ".instr"}, if_id_instr, m_instr);
    chk({tag, ".ipc"},   if_id_pc, m_ipc);
    chk({tag, ".valid"}, {31'b0, if_id_valid}, {31'b0, m_valid});
    chk({tag, ".fcnt"},  {28'b0, fetch_cnt}, PERF ? m_fc  : 0);
    chk({tag, ".flcnt"}, {28'b0, flush_cnt}, PERF ? m_flc : 0);
    chk({tag, ".stcnt"}, {28'b0, stall_cnt}, PERF ? m_stc : 0);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, ".pc"},    pc, 32'h0);
    chk({tag, ".instr"}, if_id_instr, NOP);
    chk({tag, ".ipc"},   if_id_pc, 32'h0);
    chk({tag, ".valid"}, {31'b0, if_id_valid}, 32'h0);
    chk({tag, ".cnts"},  {20'b0, fetch_cnt, flush_cnt, stall_cnt}, 32'h0);
  endtask

  typedef struct {
    logic        e, s, f, r;
    logic [31:0] rp;
    logic [31:0] e_pc, e_ipc;
    logic        e_valid;
    int unsigned e_fc, e_flc, e_stc;
  } vec_t;

  vec_t tbl[12];

  initial begin
    // Table starts from pc=0 right after reset.
    tbl[0]  = '{1,0,0,0, 32'h0,   32'h04,  32'h00, 1, 1,0,0};
    tbl[1]  = '{1,0,0,0, 32'h0,   32'h08,  32'h04, 1, 2,0,0};
    tbl[2]  = '{1,1,0,0, 32'h0,   32'h08,  32'h04, 1, 2,0,1};
    tbl[3]  = '{1,1,0,0, 32'h0,   32'h08,  32'h04, 1, 2,0,2};
    tbl[4]  = '{1,1,0,0, 32'h0,   32'h08,  32'h04, 1, 2,0,3};
    tbl[5]  = '{1,0,0,0, 32'h0,   32'h0C,  32'h08, 1, 3,0,3};
    tbl[6]  = '{1,0,0,0, 32'h0,   32'h10,  32'h0C, 1, 4,0,3};
    tbl[7]  = '{1,1,1,1, 32'h40,  32'h40,  32'h10, 0, 4,1,3};
    tbl[8]  = '{1,0,0,0, 32'h0,   32'h44,  32'h40, 1, 5,1,3};
    tbl[9]  = '{0,1,1,1, 32'h80,  32'h44,  32'h40, 1, 5,1,3};
    tbl[10] = '{1,0,0,1, 32'h123, 32'h120, 32'h44, 1, 6,1,3};
    tbl[11] = '{1,0,0,0, 32'h0,   32'h124, 32'h120,1, 7,1,3};

    arst_n = 1'b0; en = 0; stall = 0; IF_flush = 0; redirect = 0; redirect_pc = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk_reset_vals("rst0");
    arst_n = 1'b1;

    // First edge after release fetches the word at 0.
    step(1, 0, 0, 0, 0);
    chk("t1.instr", if_id_instr, 32'h0050_0093);
    chk("t1.ipc", if_id_pc, 32'h0);
    chk("t1.pc", pc, 32'h4);
    step(1, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0);

    // Asynchronous reset mid-cycle: outputs return without a clock edge.
    #2 arst_n = 1'b0;
    #1 chk_reset_vals("t1.async");
    @(posedge clk);
    #1 arst_n = 1'b1;
    model_reset();

    for (int i = 0; i < 12; i++) begin
      string tag;
      logic [31:0] e_instr;
      tag = $sformatf("tbl%0d", i);
      step(tbl[i].e, tbl[i].s, tbl[i].f, tbl[i].r, tbl[i].rp);
      e_instr = tbl[i].e_valid ? mem_word(tbl[i].e_ipc) : NOP;
      chk({tag, ".pc"},    pc, tbl[i].e_pc);
      chk({tag, ".ipc"},   if_id_pc, tbl[i].e_ipc);
      chk({tag, ".valid"}, {31'b0, if_id_valid}, {31'b0, tbl[i].e_valid});
      chk({tag, ".instr"}, if_id_instr, e_instr);
      chk({tag, ".fcnt"},  {28'b0, fetch_cnt}, PERF ? tbl[i].e_fc  : 0);
      chk({tag, ".flcnt"}, {28'b0, flush_cnt}, PERF ? tbl[i].e_flc : 0);
      chk({tag, ".stcnt"}, {28'b0, stall_cnt}, PERF ? tbl[i].e_stc : 0);
    end

    // PC wrap at the top of the address space.
    step(1, 0, 1, 1, 32'hFFFF_FFFE);
    chk("t5.pc_top", pc, 32'hFFFF_FFFC);
    step(1, 0, 0, 0, 0);
    chk("t5.wrap_pc", pc, 32'h0);
    chk("t5.wrap_ipc", if_id_pc, 32'hFFFF_FFFC);
    chk("t5.wrap_instr", if_id_instr, mem_word(32'hFFFF_FFFC));
    cmp_model("t5");

    // Randomized run against the model; long enough to saturate the counters.
    for (int i = 0; i < 400; i++) begin
      logic [31:0] rp;
      rp = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | $urandom_range(0, 15)) : $urandom;
      step($urandom_range(0, 7) != 0, $urandom_range(0, 3) == 0,
           $urandom_range(0, 5) == 0, $urandom_range(0, 5) == 0, rp);
      cmp_model($sformatf("rnd%0d", i));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
